// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, common keyboard
// command bytes and helpers that turn microsecond/millisecond timings into clock cycles.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      INHIBIT  = 4'd1,
      RTS      = 4'd2,
      DATA     = 4'd3,
      PARITY   = 4'd4,
      STOP     = 4'd5,
      ACK_WAIT = 4'd6,
      DONE     = 4'd7,
      ERR      = 4'd8
   } ps2_state_t;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

   // Integer-MHz divide first so the intermediate product stays within 32 bits.
   function automatic int inhibit_cycles(input int clock_frequency, input int inhibit_us);
      return (clock_frequency / 1_000_000) * inhibit_us;
   endfunction

   function automatic int timeout_cycles(input int clock_frequency, input int timeout_ms);
      return (clock_frequency / 1000) * timeout_ms;
   endfunction

   function automatic int counter_width(input int timeout_cyc);
      return $clog2(timeout_cyc) + 1;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 pin plus a falling-edge strobe.
// Shared by the host transmitter and the keyboard receiver.
module ps2_line_sync (
   input  logic Clock,
   input  logic reset,
   input  logic line_in,
   output logic line_sync,
   output logic line_fall
);

   logic line_meta;
   logic line_prev;

   // Flops reset to the idle-high bus level so a released line never fakes an edge.
   always_ff @(posedge Clock) begin
      if (reset) begin
         line_meta <= 1'b1;
         line_sync <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         line_meta <= line_in;
         line_sync <= line_meta;
         line_prev <= line_sync;
      end
   end

   assign line_fall = line_prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device clock falling edges and checks the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 25_000_000,
   parameter int INHIBIT_US      = 120,
   parameter int TIMEOUT_MS      = 20
) (
   input  logic       Clock,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] cmd,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int INHIBIT_CYC = inhibit_cycles(CLOCK_FREQUENCY, INHIBIT_US);
   localparam int TIMEOUT_CYC = timeout_cycles(CLOCK_FREQUENCY, TIMEOUT_MS);
   localparam int CW          = counter_width(TIMEOUT_CYC);

   localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] TIMER_STEP   = CW'(1);

   ps2_state_t    state;
   ps2_state_t    next_state;
   logic [CW-1:0] timer;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic          timeout;

   logic          clk_sync;
   logic          clk_fall;
   logic          dat_sync;
   logic          dat_fall_unused;

   ps2_line_sync u_clk_sync (
      .Clock     (Clock),
      .reset     (reset),
      .line_in   (ps2_clk_in),
      .line_sync (clk_sync),
      .line_fall (clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .Clock     (Clock),
      .reset     (reset),
      .line_in   (ps2_dat_in),
      .line_sync (dat_sync),
      .line_fall (dat_fall_unused)
   );

   // One timer serves both phases: it measures the inhibit pulse, then restarts at
   // zero on entry to RTS and bounds the rest of the transfer.
   assign timeout = (timer == TIMEOUT_LAST);

   always_ff @(posedge Clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Timeout is tested ahead of the clock edge so it wins when both land together.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (send) next_state = INHIBIT;
         end
         INHIBIT: begin
            if (timer == INHIBIT_LAST) next_state = RTS;
         end
         RTS: begin
            if (timeout)       next_state = ERR;
            else if (clk_fall) next_state = DATA;
         end
         DATA: begin
            if (timeout)                           next_state = ERR;
            else if (clk_fall && bit_cnt == 4'd7) next_state = PARITY;
         end
         PARITY: begin
            if (timeout)       next_state = ERR;
            else if (clk_fall) next_state = STOP;
         end
         STOP: begin
            if (timeout)       next_state = ERR;
            else if (clk_fall) next_state = dat_sync ? ERR : ACK_WAIT;
         end
         ACK_WAIT: begin
            if (timeout)                  next_state = ERR;
            else if (clk_sync && dat_sync) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Byte, parity and counters are captured only on an accepted send, so a send
   // that arrives while busy cannot disturb the frame in flight.
   always_ff @(posedge Clock) begin
      if (reset) begin
         timer      <= '0;
         bit_cnt    <= 4'd0;
         shift_reg  <= 8'h00;
         parity_bit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (send) begin
                  shift_reg  <= cmd;
                  parity_bit <= ~^cmd;
                  bit_cnt    <= 4'd0;
                  timer      <= '0;
               end
            end
            INHIBIT: begin
               timer <= (timer == INHIBIT_LAST) ? '0 : timer + TIMER_STEP;
            end
            DATA: begin
               timer <= timer + TIMER_STEP;
               if (clk_fall && !timeout && bit_cnt != 4'd7) begin
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 4'd1;
               end
            end
            RTS, PARITY, STOP, ACK_WAIT: begin
               timer <= timer + TIMER_STEP;
            end
            default: begin
            end
         endcase
      end
   end

   // Enables are open-drain pull-downs: a 1 drives the line low, a 0 releases it.
   always_comb begin
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            busy       = 1'b1;
         end
         RTS: begin
            ps2_dat_oe = 1'b1;
            busy       = 1'b1;
         end
         DATA: begin
            ps2_dat_oe = ~shift_reg[0];
            busy       = 1'b1;
         end
         PARITY: begin
            ps2_dat_oe = ~parity_bit;
            busy       = 1'b1;
         end
         STOP, ACK_WAIT: begin
            busy = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         ERR: begin
            error = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 device clocking at ~12.5 kHz
// against a 1 MHz system clock; expected device-sampled frames flow through a queue.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int HALF = 40;

   logic       Clock = 1'b0;
   logic       reset = 1'b1;
   logic       send  = 1'b0;
   logic [7:0] cmd   = 8'h00;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       clk_pin;
   logic       dat_pin;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       done;
   logic       error;

   int checks = 0;
   int failures = 0;
   int done_pulses = 0;
   int error_pulses = 0;
   int dev_fall_count = 0;

   logic [9:0] exp_q[$];

   assign clk_pin = ~(ps2_clk_oe | dev_clk_low);
   assign dat_pin = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLOCK_FREQUENCY (1_000_000),
      .INHIBIT_US      (120),
      .TIMEOUT_MS      (20)
   ) dut (
      .Clock      (Clock),
      .reset      (reset),
      .send       (send),
      .cmd        (cmd),
      .ps2_clk_in (clk_pin),
      .ps2_dat_in (dat_pin),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 Clock = ~Clock;

   // Pulse tallies let tests confirm an outcome occurred exactly once or never.
   always @(negedge Clock) begin
      if (done)  done_pulses  <= done_pulses + 1;
      if (error) error_pulses <= error_pulses + 1;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // Frame as the device samples it: 8 data bits LSB first, odd parity, stop.
   function automatic logic [9:0] frame_model(input logic [7:0] c);
      logic par;
      par = (($countones(c) % 2) == 0);
      return {1'b1, par, c};
   endfunction

   task automatic do_send(input logic [7:0] c, input bit track);
      send = 1'b1;
      cmd  = c;
      if (track) exp_q.push_back(frame_model(c));
      @(negedge Clock);
      send = 1'b0;
      cmd  = ~c;
   endtask

   task automatic device_transfer(input bit give_ack, output logic [9:0] frame, output bit timed_out);
      int guard;
      frame = '0;
      timed_out = 1'b0;
      dev_fall_count = 0;
      guard = 0;
      while (!(clk_pin === 1'b1 && dat_pin === 1'b0) && guard < 2000) begin
         @(negedge Clock);
         guard++;
      end
      if (guard >= 2000) begin
         timed_out = 1'b1;
         return;
      end
      wait_cycles(30);
      for (int i = 0; i < 11; i++) begin
         dev_clk_low = 1'b1;
         dev_fall_count++;
         wait_cycles(HALF);
         dev_clk_low = 1'b0;
         if (i < 10) frame[i] = dat_pin;
         if (i == 9) begin
            wait_cycles(HALF / 2);
            if (give_ack) dev_dat_low = 1'b1;
            wait_cycles(HALF - HALF / 2);
         end else if (i == 10) begin
            dev_dat_low = 1'b0;
         end else begin
            wait_cycles(HALF);
         end
      end
   endtask

   task automatic wait_outcome(input int budget, output bit saw_done, output bit saw_err, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && error !== 1'b1 && cyc < budget) begin
         @(negedge Clock);
         cyc++;
      end
      saw_done = (done === 1'b1);
      saw_err  = (error === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_cycles(3);
      checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
      checks++; if (ps2_dat_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_dat_oe: got %b expected 0", ps2_dat_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
      reset = 1'b0;
      wait_cycles(5);
   endtask

   task automatic test_set_leds();
      int d0, e0, cnt, cyc;
      bit to, sd, se;
      logic [9:0] frame, expf;
      d0 = done_pulses;
      e0 = error_pulses;
      do_send(PS2_CMD_SET_LEDS, 1'b1);
      checks++; if (ps2_clk_oe !== 1'b1) begin failures++; $display("[TB] FAIL leds_clk_oe_latency: got %b expected 1", ps2_clk_oe); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL leds_busy_rise: got %b expected 1", busy); end
      cnt = 0;
      while (ps2_clk_oe === 1'b1 && cnt < 1000) begin
         cnt++;
         @(negedge Clock);
      end
      checks++; if (cnt != 120) begin failures++; $display("[TB] FAIL leds_inhibit_len: got %0d expected 120", cnt); end
      checks++; if (ps2_dat_oe !== 1'b1) begin failures++; $display("[TB] FAIL leds_start_bit: dat_oe got %b expected 1", ps2_dat_oe); end
      device_transfer(1'b1, frame, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL leds_rts_seen: got timeout expected rts"); end
      expf = exp_q.pop_front();
      checks++; if (frame !== expf) begin failures++; $display("[TB] FAIL leds_frame: got %b expected %b", frame, expf); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL leds_busy_before_done: got %b expected 1", busy); end
      wait_outcome(50, sd, se, cyc);
      checks++; if (!sd) begin failures++; $display("[TB] FAIL leds_done: got done=%b error=%b expected done", sd, se); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL leds_busy_with_done: got %b expected 0", busy); end
      @(negedge Clock);
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL leds_done_width: got %b expected 0", done); end
      wait_cycles(10);
      checks++; if (done_pulses - d0 != 1) begin failures++; $display("[TB] FAIL leds_done_count: got %0d expected 1", done_pulses - d0); end
      checks++; if (error_pulses - e0 != 0) begin failures++; $display("[TB] FAIL leds_error_count: got %0d expected 0", error_pulses - e0); end
   endtask

   task automatic test_parity();
      int cyc;
      bit to, sd, se;
      logic [9:0] frame, expf;
      logic [7:0] c;
      logic exp_par;
      for (int i = 0; i < 2; i++) begin
         c       = (i == 0) ? 8'h01 : 8'h00;
         exp_par = (i == 0) ? 1'b0 : 1'b1;
         do_send(c, 1'b1);
         device_transfer(1'b1, frame, to);
         expf = exp_q.pop_front();
         checks++; if (frame !== expf) begin failures++; $display("[TB] FAIL parity_frame_%02h: got %b expected %b", c, frame, expf); end
         checks++; if (frame[8] !== exp_par) begin failures++; $display("[TB] FAIL parity_bit_%02h: got %b expected %b", c, frame[8], exp_par); end
         wait_outcome(50, sd, se, cyc);
         checks++; if (!sd || se) begin failures++; $display("[TB] FAIL parity_done_%02h: got done=%b error=%b expected done", c, sd, se); end
         wait_cycles(10);
      end
   endtask

   task automatic test_timeout();
      int cnt, cyc;
      bit sd, se;
      do_send(PS2_CMD_ENABLE, 1'b0);
      cnt = 0;
      while (ps2_clk_oe === 1'b1 && cnt < 1000) begin
         cnt++;
         @(negedge Clock);
      end
      wait_outcome(20100, sd, se, cyc);
      checks++; if (!se || sd) begin failures++; $display("[TB] FAIL timeout_error: got done=%b error=%b expected error", sd, se); end
      checks++; if (cyc != 20000) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d expected 20000", cyc); end
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin failures++; $display("[TB] FAIL timeout_release: got clk_oe=%b dat_oe=%b expected 0 0", ps2_clk_oe, ps2_dat_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
      wait_cycles(5);
   endtask

   task automatic test_no_ack();
      int d0, e0;
      bit to;
      logic [9:0] frame, expf;
      d0 = done_pulses;
      e0 = error_pulses;
      do_send(PS2_CMD_RESET, 1'b1);
      device_transfer(1'b0, frame, to);
      expf = exp_q.pop_front();
      checks++; if (frame !== expf) begin failures++; $display("[TB] FAIL noack_frame: got %b expected %b", frame, expf); end
      wait_cycles(10);
      checks++; if (error_pulses - e0 != 1) begin failures++; $display("[TB] FAIL noack_error_count: got %0d expected 1", error_pulses - e0); end
      checks++; if (done_pulses - d0 != 0) begin failures++; $display("[TB] FAIL noack_done_count: got %0d expected 0", done_pulses - d0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL noack_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit to, sd, se;
      logic [9:0] frame, expf;
      do_send(PS2_CMD_ENABLE, 1'b1);
      fork
         device_transfer(1'b1, frame, to);
         begin
            wait_cycles(300);
            send = 1'b1;
            cmd  = PS2_CMD_RESET;
            @(negedge Clock);
            send = 1'b0;
         end
      join
      expf = exp_q.pop_front();
      checks++; if (frame !== expf) begin failures++; $display("[TB] FAIL b2b_first_frame: got %b expected %b", frame, expf); end
      wait_outcome(50, sd, se, cyc);
      checks++; if (!sd) begin failures++; $display("[TB] FAIL b2b_first_done: got done=%b error=%b expected done", sd, se); end
      send = 1'b1;
      cmd  = 8'h00;
      exp_q.push_back(frame_model(8'h00));
      @(negedge Clock);
      checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("[TB] FAIL b2b_send_in_done: clk_oe got %b expected 0", ps2_clk_oe); end
      @(negedge Clock);
      send = 1'b0;
      cmd  = 8'hAA;
      checks++; if (ps2_clk_oe !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart_latency: clk_oe got %b expected 1", ps2_clk_oe); end
      device_transfer(1'b1, frame, to);
      expf = exp_q.pop_front();
      checks++; if (frame !== expf) begin failures++; $display("[TB] FAIL b2b_second_frame: got %b expected %b", frame, expf); end
      wait_outcome(50, sd, se, cyc);
      checks++; if (!sd) begin failures++; $display("[TB] FAIL b2b_second_done: got done=%b error=%b expected done", sd, se); end
      wait_cycles(10);
   endtask

   task automatic test_reset_mid_frame();
      int d0, e0, guard, cyc;
      bit to, sd, se;
      logic [9:0] frame, expf;
      d0 = done_pulses;
      e0 = error_pulses;
      do_send(PS2_CMD_SET_LEDS, 1'b0);
      fork
         device_transfer(1'b1, frame, to);
         begin
            wait_cycles(1);
            guard = 0;
            while (dev_fall_count < 5 && guard < 2000) begin
               @(negedge Clock);
               guard++;
            end
            wait_cycles(10);
            checks++; if (ps2_dat_oe !== 1'b1) begin failures++; $display("[TB] FAIL rst_bit4_presented: dat_oe got %b expected 1", ps2_dat_oe); end
            reset = 1'b1;
            @(negedge Clock);
            checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin failures++; $display("[TB] FAIL rst_release: got clk_oe=%b dat_oe=%b expected 0 0", ps2_clk_oe, ps2_dat_oe); end
            checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
            checks++; if (done !== 1'b0 || error !== 1'b0) begin failures++; $display("[TB] FAIL rst_pulses: got done=%b error=%b expected 0 0", done, error); end
            reset = 1'b0;
         end
      join
      wait_cycles(10);
      checks++; if (done_pulses - d0 != 0 || error_pulses - e0 != 0) begin failures++; $display("[TB] FAIL rst_no_outcome: got done=%0d error=%0d expected 0 0", done_pulses - d0, error_pulses - e0); end
      do_send(PS2_CMD_ENABLE, 1'b1);
      device_transfer(1'b1, frame, to);
      expf = exp_q.pop_front();
      checks++; if (frame !== expf) begin failures++; $display("[TB] FAIL rst_after_frame: got %b expected %b", frame, expf); end
      wait_outcome(50, sd, se, cyc);
      checks++; if (!sd || se) begin failures++; $display("[TB] FAIL rst_after_done: got done=%b error=%b expected done", sd, se); end
      wait_cycles(10);
   endtask

   initial begin
      $display("[TB] starting ps2_host_tx bench");
      test_reset();
      test_set_leds();
      test_parity();
      test_timeout();
      test_no_ack();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
